// File: rtl/mite_pkg.sv
// Shared types for the mite accumulator core: opcode and FSM state enums
// plus the instruction-width helper.
package mite_pkg;

  typedef enum logic [2:0] {
    OP_LDI  = 3'b000,
    OP_ADD  = 3'b001,
    OP_STO  = 3'b010,
    OP_BLE  = 3'b011,
    OP_LD   = 3'b100,
    OP_SUB  = 3'b101,
    OP_NAND = 3'b110,
    OP_HALT = 3'b111
  } opcode_t;

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_RUN,
    ST_HALT
  } state_t;

  function automatic int instr_width(input int operand_width);
    return operand_width + 3;
  endfunction

endpackage

// File: rtl/mite_alu.sv
// Combinational next-accumulator logic for the mite core.
// MITE_CORE_SUB_EN enables the subtractor; otherwise SUB leaves acc unchanged.
module mite_alu
  import mite_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  opcode_t               op,
  input  logic [DATA_WIDTH-1:0] acc,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic [DATA_WIDTH-1:0] imm,
  output logic [DATA_WIDTH-1:0] next_acc
);

  always_comb begin
    // NOTE: default assignment first so every path drives next_acc and no latch is inferred.
    next_acc = acc;
    case (op)
      OP_LDI:  next_acc = imm;
      OP_ADD:  next_acc = acc + mem_data;
`ifdef MITE_CORE_SUB_EN
      OP_SUB:  next_acc = acc - mem_data;
`endif
      OP_NAND: next_acc = ~(acc & mem_data);
      OP_LD:   next_acc = mem_data;
      default: next_acc = acc;
    endcase
  end

endmodule

// File: rtl/mite_core.sv
// Parametrised accumulator processor: CLEAR/IDLE/RUN/HALT control, writable
// instruction memory, self-clearing data memory. MITE_CORE_SUB_EN enables SUB.
module mite_core
  import mite_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int IMEM_ADDR_WIDTH = 8,
  parameter int DMEM_ADDR_WIDTH = 8,
  parameter int OPERAND_WIDTH   = 8
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  run,
  input  logic                                  imem_we,
  input  logic [IMEM_ADDR_WIDTH-1:0]            imem_waddr,
  input  logic [instr_width(OPERAND_WIDTH)-1:0] imem_wdata,
  output logic                                  busy,
  output logic                                  halted,
  output logic [IMEM_ADDR_WIDTH-1:0]            pc,
  output logic [DATA_WIDTH-1:0]                 result
);

  localparam int INSTR_WIDTH = instr_width(OPERAND_WIDTH);
  localparam int IMEM_DEPTH  = 1 << IMEM_ADDR_WIDTH;
  localparam int DMEM_DEPTH  = 1 << DMEM_ADDR_WIDTH;

  logic [INSTR_WIDTH-1:0] imem [IMEM_DEPTH];
  logic [DATA_WIDTH-1:0]  dmem [DMEM_DEPTH];

  state_t                     state;
  logic [DATA_WIDTH-1:0]      acc;
  logic [DMEM_ADDR_WIDTH-1:0] clr_addr;

  logic [INSTR_WIDTH-1:0]     instr;
  opcode_t                    op;
  logic [OPERAND_WIDTH-1:0]   operand;
  logic [DMEM_ADDR_WIDTH-1:0] daddr;
  logic [DATA_WIDTH-1:0]      mem_data;
  logic [DATA_WIDTH-1:0]      alu_acc;
  logic                       ble_taken;

  logic                       dmem_we;
  logic [DMEM_ADDR_WIDTH-1:0] dmem_waddr;
  logic [DATA_WIDTH-1:0]      dmem_wdata;

  assign instr     = imem[pc];
  assign op        = opcode_t'(instr[OPERAND_WIDTH+2:OPERAND_WIDTH]);
  assign operand   = instr[OPERAND_WIDTH-1:0];
  assign daddr     = operand[DMEM_ADDR_WIDTH-1:0];
  assign mem_data  = dmem[daddr];
  assign ble_taken = acc[DATA_WIDTH-1] || (acc == '0);
  assign result    = dmem[0];

  mite_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .op       (op),
    .acc      (acc),
    .mem_data (mem_data),
    .imm      (operand[DATA_WIDTH-1:0]),
    .next_acc (alu_acc)
  );

  // CLEAR sweeps zeros through the data memory; in RUN only STO writes it.
  always_comb begin
    dmem_we    = 1'b0;
    dmem_waddr = clr_addr;
    dmem_wdata = '0;
    if (!reset) begin
      if (state == ST_CLEAR) begin
        dmem_we = 1'b1;
      end else if (state == ST_RUN && op == OP_STO) begin
        dmem_we    = 1'b1;
        dmem_waddr = daddr;
        dmem_wdata = acc;
      end
    end
  end

  // NOTE: memory arrays carry no reset; CLEAR initialises dmem and imem is loaded by the host.
  always_ff @(posedge clk) begin
    if (imem_we) imem[imem_waddr] <= imem_wdata;
    if (dmem_we) dmem[dmem_waddr] <= dmem_wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_CLEAR;
      clr_addr <= '0;
      pc       <= '0;
      acc      <= '0;
      busy     <= 1'b1;
      halted   <= 1'b0;
    end else begin
      case (state)
        ST_CLEAR: begin
          if (&clr_addr) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            clr_addr <= clr_addr + 1'b1;
          end
        end
        ST_IDLE: begin
          pc  <= '0;
          acc <= '0;
          if (run) begin
            state <= ST_RUN;
            busy  <= 1'b1;
          end
        end
        ST_RUN: begin
          case (op)
            OP_STO: pc <= pc + 1'b1;
            OP_BLE: pc <= ble_taken ? operand[IMEM_ADDR_WIDTH-1:0] : pc + 1'b1;
            OP_HALT: begin
              state  <= ST_HALT;
              busy   <= 1'b0;
              halted <= 1'b1;
            end
            default: begin
              acc <= alu_acc;
              pc  <= pc + 1'b1;
            end
          endcase
        end
        ST_HALT: begin
          if (!run) begin
            state  <= ST_IDLE;
            pc     <= '0;
            acc    <= '0;
            halted <= 1'b0;
          end
        end
        default: state <= ST_CLEAR;
      endcase
    end
  end

endmodule
